button_event: RTL and testbench

//   Consumes the clean, synchronous level produced by the input debouncer and turns it into

---
 rtl/button_pkg.sv | 10 +
 rtl/event_timer.sv | 21 ++
 rtl/button_event.sv | 87 ++++++++
 tb/tb_button_event.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/button_pkg.sv
// Shared encodings and helpers for the button event block.
package button_pkg;
  localparam logic [1:0] BTN_IDLE  = 2'd0;
  localparam logic [1:0] BTN_SHORT = 2'd1;
  localparam logic [1:0] BTN_LONG  = 2'd2;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction
endpackage

// File: rtl/event_timer.sv
// Clear/enable up-counter with a terminal-count compare against a supplied value.
module event_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] tc_val,
  output logic         tc
);
  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   count <= '0;
    else if (clr) count <= '0;
    else if (en)  count <= count + 1'b1;
  end

  assign tc = (count == tc_val);
endmodule

// File: rtl/button_event.sv
// Turns a debounced button level into press/release/long-press/repeat pulses,
// a held flag and a wrapping press counter.
module button_event
  import button_pkg::*;
#(
  parameter int LONG_CNT   = 50000,
  parameter int REPEAT_CNT = 10000,
  parameter int REPEAT_EN  = 1,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in,
  output logic             press,
  output logic             release_ev,
  output logic             long_press,
  output logic             repeat_ev,
  output logic             held,
  output logic [CNT_W-1:0] press_count
);
  localparam int TW = $clog2(max2(LONG_CNT, REPEAT_CNT));
  localparam logic [TW-1:0] LONG_TC = TW'(LONG_CNT - 1);
  localparam logic [TW-1:0] REP_TC  = TW'(REPEAT_CNT - 1);
  localparam logic          REP_ON  = (REPEAT_EN != 0);

  logic [1:0] state, state_nxt;
  logic       in_d, rise, tc, tmr_clr, tmr_en;
  logic       press_nxt, rel_nxt, long_nxt, rpt_nxt, held_nxt;

  assign rise = in & ~in_d;

  event_timer #(.W(TW)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (tmr_clr),
    .en     (tmr_en),
    .tc_val ((state == BTN_SHORT) ? LONG_TC : REP_TC),
    .tc     (tc)
  );

  // State register; every output is registered alongside it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= BTN_IDLE;
      in_d        <= 1'b0;
      press       <= 1'b0;
      release_ev  <= 1'b0;
      long_press  <= 1'b0;
      repeat_ev   <= 1'b0;
      held        <= 1'b0;
      press_count <= '0;
    end else begin
      state       <= state_nxt;
      in_d        <= in;
      press       <= press_nxt;
      release_ev  <= rel_nxt;
      long_press  <= long_nxt;
      repeat_ev   <= rpt_nxt;
      held        <= held_nxt;
      if (press_nxt) press_count <= press_count + 1'b1;
    end
  end

  // Next state and timer control; the timer restarts on any state change.
  always_comb begin
    state_nxt = state;
    case (state)
      BTN_IDLE:  if (rise) state_nxt = BTN_SHORT;
      BTN_SHORT: if (!in) state_nxt = BTN_IDLE;
                 else if (tc) state_nxt = BTN_LONG;
      BTN_LONG:  if (!in) state_nxt = BTN_IDLE;
      default:   state_nxt = BTN_IDLE;
    endcase
    tmr_clr = (state_nxt != state) || (state == BTN_IDLE) ||
              ((state == BTN_LONG) && REP_ON && tc);
    tmr_en  = (state == BTN_SHORT) || ((state == BTN_LONG) && REP_ON);
  end

  // Pulse decode: release takes priority because terminal counts require in=1.
  always_comb begin
    press_nxt = (state == BTN_IDLE) && rise;
    rel_nxt   = ((state == BTN_SHORT) || (state == BTN_LONG)) && !in;
    long_nxt  = (state == BTN_SHORT) && in && tc;
    rpt_nxt   = (state == BTN_LONG) && in && REP_ON && tc;
    held_nxt  = (state_nxt == BTN_SHORT) || (state_nxt == BTN_LONG);
  end
endmodule

// File: tb/tb_button_event.sv
// Directed bench for button_event: LONG_CNT=8, REPEAT_CNT=4, plus a REPEAT_EN=0 twin.
module tb_button_event;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in = 1'b0;
  logic       press, release_ev, long_press, repeat_ev, held;
  logic [7:0] press_count;
  logic       press2, release2, long2, repeat2, held2;
  logic [7:0] count2;

  int n_chk = 0, n_err = 0;
  int n_press, n_rel, n_long, n_rpt, n_rpt2, n_long2, n_held, n_mutex;
  int t_press, t_rel, t_long;
  int rpt_t [0:15];

  always #5 clk = ~clk;

  button_event #(.LONG_CNT(8), .REPEAT_CNT(4), .REPEAT_EN(1), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in(in), .press(press), .release_ev(release_ev),
    .long_press(long_press), .repeat_ev(repeat_ev), .held(held), .press_count(press_count)
  );

  button_event #(.LONG_CNT(8), .REPEAT_CNT(4), .REPEAT_EN(0), .CNT_W(8)) dut2 (
    .clk(clk), .rst_n(rst_n), .in(in), .press(press2), .release_ev(release2),
    .long_press(long2), .repeat_ev(repeat2), .held(held2), .press_count(count2)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Drive hi cycles of in=1 then lo cycles of in=0; sample each edge's result on the next negedge.
  task automatic run(input int hi, input int lo);
    n_press = 0; n_rel = 0; n_long = 0; n_rpt = 0; n_rpt2 = 0; n_long2 = 0;
    n_held = 0; n_mutex = 0; t_press = -1; t_rel = -1; t_long = -1;
    for (int k = 0; k < hi + lo; k++) begin
      in = (k < hi);
      @(negedge clk);
      if (press)      begin n_press++; t_press = k; end
      if (release_ev) begin n_rel++;   t_rel = k;   end
      if (long_press) begin n_long++;  t_long = k;  end
      if (repeat_ev)  begin if (n_rpt < 16) rpt_t[n_rpt] = k; n_rpt++; end
      if (repeat2) n_rpt2++;
      if (long2)   n_long2++;
      if (held)    n_held++;
      if (32'(press) + 32'(release_ev) + 32'(long_press) + 32'(repeat_ev) > 1) n_mutex++;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; in = 1'b0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
  endtask

  int total;

  initial begin
    // 1. reset
    #2;
    check("rst_outs", {27'd0, press, release_ev, long_press, repeat_ev, held}, 0);
    check("rst_count", press_count, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    run(0, 10);
    check("idle_pulses", n_press + n_rel + n_long + n_rpt, 0);
    check("idle_count", press_count, 0);

    // 2. short press
    run(3, 3);
    check("short_press_n", n_press, 1);
    check("short_press_t", t_press, 0);
    check("short_rel_n", n_rel, 1);
    check("short_rel_t", t_rel, 3);
    check("short_held", n_held, 3);
    check("short_long", n_long, 0);
    check("short_count", press_count, 1);

    // 3. long hold
    run(22, 4);
    check("long_press_t", t_press, 0);
    check("long_t", t_long, 8);
    check("long_n", n_long, 1);
    check("long_rpt_n", n_rpt, 3);
    check("long_rpt0", rpt_t[0], 12);
    check("long_rpt1", rpt_t[1], 16);
    check("long_rpt2", rpt_t[2], 20);
    check("long_rel_t", t_rel, 22);
    check("long_held", n_held, 22);
    check("long_mutex", n_mutex, 0);
    check("long_count", press_count, 2);

    // 4. coincidences
    run(8, 3);
    check("co_short_rel_t", t_rel, 8);
    check("co_short_long", n_long, 0);
    run(12, 3);
    check("co_long_t", t_long, 8);
    check("co_long_rel_t", t_rel, 12);
    check("co_long_rpt", n_rpt, 0);
    check("co_count", press_count, 4);

    // 5. wrap and repeat disable
    do_reset();
    total = 0;
    for (int i = 0; i < 256; i++) begin
      run(1, 1);
      total += n_press;
    end
    check("wrap_presses", total, 256);
    check("wrap_count0", press_count, 0);
    run(1, 1);
    check("wrap_count1", press_count, 1);
    run(40, 2);
    check("noreps_dut2_rpt", n_rpt2, 0);
    check("noreps_dut2_long", n_long2, 1);
    check("noreps_dut1_rpt", n_rpt, 7);
    check("noreps_rel_t", t_rel, 40);

    // 6. async reset mid-hold
    in = 1'b1;
    repeat (12) @(negedge clk);
    check("mid_held_pre", held, 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_outs", {27'd0, press, release_ev, long_press, repeat_ev, held}, 0);
    check("mid_rst_count", press_count, 0);
    check("mid_rst_held2", held2, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_press", press, 1);
    check("post_rst_held", held, 1);
    check("post_rst_count", press_count, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
